// File: rtl/data_memory_split.sv
// ----------------------------------------------------------------------------
// data_memory_split
//
// Byte-addressable, little-endian data memory of DEPTH_WORDS 32-bit words.
// It serves byte, halfword and word loads and stores. Loads are registered,
// so the result appears one cycle after acceptance.
//
// An access whose bytes span two words is called "crossing". What happens to
// it depends on the build macro MISALIGNED_SPLIT_EN:
//   defined   : the access is split across two cycles (IDLE -> SECOND).
//               ready is low while the FSM is in SECOND.
//   undefined : the access is rejected. No bytes are written, and
//               misaligned_fault pulses for one cycle.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset (memory is not cleared)
//   read / write     load / store request; if both are high, only the store
//                    is performed
//   sign_extend      loads: 1 = sign-extend, 0 = zero-extend
//   load_type        access size: byte / hword / word mask encoding; any
//                    other code is treated as word
//   long_addr        byte address; wraps modulo 4*DEPTH_WORDS
//   write_value      store data, right-justified
//   ready            a request is accepted on an edge where ready is high
//   read_value       registered load result
//   read_valid       one-cycle pulse when read_value holds a new result
//   misaligned_fault one-cycle pulse for a rejected crossing access
// ----------------------------------------------------------------------------
module data_memory_split #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic                  sign_extend,
    input  logic [2:0]            load_type,
    input  logic [ADDR_WIDTH-1:0] long_addr,
    input  logic [31:0]           write_value,
    output logic                  ready,
    output logic [31:0]           read_value,
    output logic                  read_valid,
    output logic                  misaligned_fault
);

    localparam logic [2:0] BYTE_MASK  = 3'b001;
    localparam logic [2:0] HWORD_MASK = 3'b011;
    localparam logic [2:0] WORD_MASK  = 3'b111;

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // Byte lanes covered by an access of the given size, at offset 0.
    function automatic logic [3:0] size_lanes(input logic [2:0] lt);
        case (lt)
            BYTE_MASK:  size_lanes = 4'b0001;
            HWORD_MASK: size_lanes = 4'b0011;
            WORD_MASK:  size_lanes = 4'b1111;
            default:    size_lanes = 4'b1111;
        endcase
    endfunction

    // Expand a byte-lane mask into a bit mask.
    function automatic logic [31:0] lane_bits(input logic [3:0] be);
        lane_bits = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Right-justified load value, extended according to the access size.
    function automatic logic [31:0] extend_load(input logic [31:0] v,
                                                input logic [3:0]  lanes,
                                                input logic        sx);
        if (!lanes[1])
            extend_load = {{24{sx & v[7]}}, v[7:0]};
        else if (!lanes[2])
            extend_load = {{16{sx & v[15]}}, v[15:0]};
        else
            extend_load = v;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       req_off;
    logic [3:0]       req_lanes;
    logic [7:0]       req_be;     // lanes of the {word w+1, word w} window
    logic [63:0]      req_wdata;  // store data aligned to that window
    logic             req_cross;
    logic             accept;
    logic             in_second;
    logic             unused_addr;

    always_comb begin
        req_idx   = long_addr[IDX_W+1:2];
        req_off   = long_addr[1:0];
        req_lanes = size_lanes(load_type);
        req_be    = {4'b0000, req_lanes} << req_off;
        req_wdata = {32'd0, write_value & lane_bits(req_lanes)} << {req_off, 3'b000};
        req_cross = |req_be[7:4];
        accept    = (read | write) & ready & ~reset;
    end

    // Upper address bits beyond the memory size are intentionally ignored.
    assign unused_addr = ^long_addr;

    // ------------------------------------------------------------------
    // Split FSM (present only when crossing accesses are split)
    // ------------------------------------------------------------------
`ifdef MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && req_cross) state_d = SECOND;
            SECOND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE);
        in_second = (state_q == SECOND);
    end
`else
    localparam logic SPLIT_EN = 1'b0;

    always_comb begin
        ready     = 1'b1;
        in_second = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Storage: a single read/modify/write port. In IDLE it addresses the
    // requested word. In SECOND it addresses the following word, for both
    // the second half of a store and the upper half of a load.
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
    logic [1:0]       hold_off_q, hold_off_d;
    logic [3:0]       hold_lanes_q, hold_lanes_d;
    logic             hold_sext_q, hold_sext_d;
    logic             hold_store_q, hold_store_d;
    logic [3:0]       hold_be_hi_q, hold_be_hi_d;
    logic [31:0]      hold_wdata_hi_q, hold_wdata_hi_d;
    logic [31:0]      hold_lo_q, hold_lo_d;

    logic [31:0] read_value_q, read_value_d;
    logic        read_valid_q, read_valid_d;
    logic        fault_q, fault_d;

    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_wword;
    logic [31:0]      merged;

    always_comb begin
        rd_idx  = in_second ? (hold_idx_q + IDX_W'(1)) : req_idx;
        rd_word = mem[rd_idx];
    end

    always_comb begin
        mem_we          = 1'b0;
        mem_be          = '0;
        mem_wdata       = '0;
        read_value_d    = read_value_q;
        read_valid_d    = 1'b0;
        fault_d         = 1'b0;
        hold_idx_d      = hold_idx_q;
        hold_off_d      = hold_off_q;
        hold_lanes_d    = hold_lanes_q;
        hold_sext_d     = hold_sext_q;
        hold_store_d    = hold_store_q;
        hold_be_hi_d    = hold_be_hi_q;
        hold_wdata_hi_d = hold_wdata_hi_q;
        hold_lo_d       = hold_lo_q;

        // Upper word on top of the captured lower word, shifted down so that
        // the first accessed byte lands in lane 0.
        merged = 32'({rd_word, hold_lo_q} >> {hold_off_q, 3'b000});

        if (in_second) begin
            if (hold_store_q) begin
                mem_we    = 1'b1;
                mem_be    = hold_be_hi_q;
                mem_wdata = hold_wdata_hi_q;
            end else begin
                read_valid_d = 1'b1;
                read_value_d = extend_load(merged, hold_lanes_q, hold_sext_q);
            end
        end else if (accept) begin
            hold_idx_d      = req_idx;
            hold_off_d      = req_off;
            hold_lanes_d    = req_lanes;
            hold_sext_d     = sign_extend;
            hold_store_d    = write;
            hold_be_hi_d    = req_be[7:4];
            hold_wdata_hi_d = req_wdata[63:32];
            hold_lo_d       = rd_word;

            if (req_cross && !SPLIT_EN) begin
                fault_d = 1'b1;
            end else if (write) begin
                mem_we    = 1'b1;
                mem_be    = req_be[3:0];
                mem_wdata = req_wdata[31:0];
            end else if (!req_cross) begin
                read_valid_d = 1'b1;
                read_value_d = extend_load(rd_word >> {req_off, 3'b000},
                                           req_lanes, sign_extend);
            end
        end

        mem_wword = (rd_word & ~lane_bits(mem_be)) | (mem_wdata & lane_bits(mem_be));
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[rd_idx] <= mem_wword;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_idx_q      <= '0;
            hold_off_q      <= '0;
            hold_lanes_q    <= '0;
            hold_sext_q     <= 1'b0;
            hold_store_q    <= 1'b0;
            hold_be_hi_q    <= '0;
            hold_wdata_hi_q <= '0;
            hold_lo_q       <= '0;
            read_value_q    <= '0;
            read_valid_q    <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            hold_idx_q      <= hold_idx_d;
            hold_off_q      <= hold_off_d;
            hold_lanes_q    <= hold_lanes_d;
            hold_sext_q     <= hold_sext_d;
            hold_store_q    <= hold_store_d;
            hold_be_hi_q    <= hold_be_hi_d;
            hold_wdata_hi_q <= hold_wdata_hi_d;
            hold_lo_q       <= hold_lo_d;
            read_value_q    <= read_value_d;
            read_valid_q    <= read_valid_d;
            fault_q         <= fault_d;
        end
    end

    assign read_value       = read_value_q;
    assign read_valid       = read_valid_q;
    assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_data_memory_split.sv
// ----------------------------------------------------------------------------
// tb_data_memory_split
//
// Directed bench for data_memory_split, using a 16-word memory.
// Inputs are driven on the falling clock edge and outputs are sampled on the
// falling edge, so each request is accepted at the rising edge in between.
// Follows MISALIGNED_SPLIT_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_data_memory_split;

    localparam int unsigned DEPTH = 16;
    localparam logic [2:0] LT_B = 3'b001;
    localparam logic [2:0] LT_H = 3'b011;
    localparam logic [2:0] LT_W = 3'b111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        sign_extend = 1'b0;
    logic [2:0]  load_type = LT_W;
    logic [31:0] long_addr = '0;
    logic [31:0] write_value = '0;
    logic        ready;
    logic [31:0] read_value;
    logic        read_valid;
    logic        misaligned_fault;

    int total = 0;
    int bad   = 0;

    data_memory_split #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .read            (read),
        .write           (write),
        .sign_extend     (sign_extend),
        .load_type       (load_type),
        .long_addr       (long_addr),
        .write_value     (write_value),
        .ready           (ready),
        .read_value      (read_value),
        .read_valid      (read_valid),
        .misaligned_fault(misaligned_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic issue(input logic rd, input logic wr, input logic sx,
                         input logic [2:0] lt, input logic [31:0] a,
                         input logic [31:0] wv);
        read = rd; write = wr; sign_extend = sx;
        load_type = lt; long_addr = a; write_value = wv;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic store(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wv);
        issue(1'b0, 1'b1, 1'b0, lt, a, wv);
    endtask

    task automatic load_chk(input string tag, input logic sx, input logic [2:0] lt,
                            input logic [31:0] a, input logic [31:0] exp);
        issue(1'b1, 1'b0, sx, lt, a, 32'h0);
        check({tag, ".valid"}, {31'b0, read_valid}, 32'd1);
        check(tag, read_value, exp);
    endtask

`ifdef MISALIGNED_SPLIT_EN
    task automatic split_load_chk(input string tag, input logic sx, input logic [2:0] lt,
                                  input logic [31:0] a, input logic [31:0] exp);
        issue(1'b1, 1'b0, sx, lt, a, 32'h0);
        check({tag, ".early"}, {31'b0, read_valid}, 32'd0);
        check({tag, ".busy"}, {31'b0, ready}, 32'd0);
        @(negedge clock);
        check({tag, ".valid"}, {31'b0, read_valid}, 32'd1);
        check(tag, read_value, exp);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        @(negedge clock);
        check("rst.ready", {31'b0, ready}, 32'd1);
        check("rst.valid", {31'b0, read_valid}, 32'd0);
        check("rst.fault", {31'b0, misaligned_fault}, 32'd0);
        check("rst.value", read_value, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Clear words 0..5, then write bytes with junk in the upper bits.
        for (int unsigned i = 0; i < 6; i++) store(LT_W, 4 * i, 32'h0);
        store(LT_B, 0, 32'hA5A5A5FE);
        store(LT_B, 3, 32'h5A5A5A04);
        store(LT_B, 6, 32'hFFFFFFF8);
        store(LT_B, 9, 32'h12345610);

        load_chk("bz0", 1'b0, LT_B, 0, 32'h000000FE);
        load_chk("bz1", 1'b0, LT_B, 1, 32'h0);
        load_chk("bz2", 1'b0, LT_B, 2, 32'h0);
        load_chk("bz3", 1'b0, LT_B, 3, 32'h00000004);
        load_chk("bz4", 1'b0, LT_B, 4, 32'h0);
        load_chk("bz5", 1'b0, LT_B, 5, 32'h0);
        load_chk("bz6", 1'b0, LT_B, 6, 32'h000000F8);
        load_chk("bs0", 1'b1, LT_B, 0, 32'hFFFFFFFE);
        load_chk("bs1", 1'b1, LT_B, 1, 32'h0);
        load_chk("bs3", 1'b1, LT_B, 3, 32'h00000004);
        load_chk("bs6", 1'b1, LT_B, 6, 32'hFFFFFFF8);
        load_chk("bz9", 1'b0, LT_B, 9, 32'h00000010);
        @(negedge clock);
        check("pulse.drop", {31'b0, read_valid}, 32'd0);

        // Halfword store and loads.
        store(LT_H, 6, 32'hDEADF830);
        load_chk("hs6", 1'b1, LT_H, 6, 32'hFFFFF830);
        load_chk("hz6", 1'b0, LT_H, 6, 32'h0000F830);
        load_chk("w4", 1'b0, LT_W, 4, 32'hF8300000);
        load_chk("b8", 1'b0, LT_B, 8, 32'h0);

        // A store followed immediately by a load of the same bytes; also an undefined size code.
        store(LT_W, 12, 32'h01020304);
        load_chk("raw12", 1'b0, LT_W, 12, 32'h01020304);
        load_chk("lt0", 1'b0, 3'b000, 12, 32'h01020304);
        load_chk("b13", 1'b1, LT_B, 13, 32'h00000003);
        load_chk("h13", 1'b1, LT_H, 13, 32'h00000203);
        load_chk("wsx", 1'b0, LT_W, 4, 32'hF8300000);

        // Read and write together: only the write is performed.
        issue(1'b1, 1'b1, 1'b0, LT_W, 0, 32'h55667788);
        check("rw.valid", {31'b0, read_valid}, 32'd0);
        load_chk("rw.w0", 1'b0, LT_W, 0, 32'h55667788);

`ifdef MISALIGNED_SPLIT_EN
        // Split word store at addr 5.
        store(LT_W, 5, 32'hAABBCCDD);
        check("ss5.busy", {31'b0, ready}, 32'd0);
        @(negedge clock);
        check("ss5.ready", {31'b0, ready}, 32'd1);
        load_chk("ss5.w1", 1'b0, LT_W, 4, 32'hBBCCDD00);
        load_chk("ss5.w2", 1'b0, LT_W, 8, 32'h000010AA);
        split_load_chk("sl5", 1'b0, LT_W, 5, 32'hAABBCCDD);
        split_load_chk("slh7s", 1'b1, LT_H, 7, 32'hFFFFAABB);
        split_load_chk("slh7z", 1'b0, LT_H, 7, 32'h0000AABB);

        // Split store across the top of memory wraps into word 0.
        store(LT_W, 4 * DEPTH - 2, 32'h11223344);
        @(negedge clock);
        load_chk("wrap.b62", 1'b0, LT_B, 4 * DEPTH - 2, 32'h00000044);
        load_chk("wrap.b63", 1'b0, LT_B, 4 * DEPTH - 1, 32'h00000033);
        load_chk("wrap.w0", 1'b0, LT_W, 0, 32'h55661122);
        split_load_chk("wrap.sl", 1'b0, LT_W, 4 * DEPTH - 2, 32'h11223344);

        // Reset during SECOND of a split store at addr 7.
        read = 1'b0; write = 1'b1; sign_extend = 1'b0;
        load_type = LT_W; long_addr = 7; write_value = 32'h99887766;
        @(posedge clock);
        #1 write = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("abort.ready", {31'b0, ready}, 32'd1);
        check("abort.valid", {31'b0, read_valid}, 32'd0);
        check("abort.value", read_value, 32'h0);
        #1 reset = 1'b0;
        @(negedge clock);
        check("abort.valid2", {31'b0, read_valid}, 32'd0);
        check("abort.ready2", {31'b0, ready}, 32'd1);
        load_chk("abort.w1", 1'b0, LT_W, 4, 32'h66CCDD00);
        load_chk("abort.w2", 1'b0, LT_W, 8, 32'h000010AA);
`else
        // Crossing accesses are rejected.
        issue(1'b1, 1'b0, 1'b0, LT_W, 2, 32'h0);
        check("mf.fault", {31'b0, misaligned_fault}, 32'd1);
        check("mf.valid", {31'b0, read_valid}, 32'd0);
        check("mf.ready", {31'b0, ready}, 32'd1);
        @(negedge clock);
        check("mf.drop", {31'b0, misaligned_fault}, 32'd0);
        store(LT_W, 2, 32'hCAFEBABE);
        check("mfs.fault", {31'b0, misaligned_fault}, 32'd1);
        store(LT_H, 3, 32'h00001234);
        check("mfh.fault", {31'b0, misaligned_fault}, 32'd1);
        load_chk("mf.w0", 1'b0, LT_W, 0, 32'h55667788);
        check("mf.clear", {31'b0, misaligned_fault}, 32'd0);
        load_chk("mf.w1", 1'b0, LT_W, 4, 32'hF8300000);
        load_chk("mf.b3", 1'b0, LT_B, 3, 32'h00000055);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_split.md
DATA_MEMORY_SPLIT -- requirements
Module: data_memory_split

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, >= 2.
REQ-002 Parameter: ADDR_WIDTH, 32, width of long_addr.
REQ-003 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: read  in  1  load request.
REQ-006 Port: write  in  1  store request.
REQ-007 Port: sign_extend  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-008 Port: load_type  in  3  access size, encoded as byte_mask / hword_mask / word_mask from the common definitions header.
REQ-009 Port: long_addr  in  ADDR_WIDTH  byte address.
REQ-010 Port: write_value  in  32  store data, right-justified.
REQ-011 Port: ready  out  1  request accepted this cycle when high.
REQ-012 Port: read_value  out  32  registered load result.
REQ-013 Port: read_valid  out  1  one-cycle pulse; read_value is valid.
REQ-014 Port: misaligned_fault  out  1  one-cycle pulse; word-crossing access rejected (macro off only).

Function
REQ-015 Storage SHALL be little-endian: byte k of word w sits at byte address 4w+k; addresses wrap modulo 4*DEPTH_WORDS.
REQ-016 A request SHALL be accepted on a rising edge where (read|write)=1 and ready=1.
REQ-017 If read and write are both high, only the write SHALL be performed; read_valid SHALL stay low for that request.
REQ-018 A non-crossing access (byte; hword with addr[1:0]!=3; word with addr[1:0]=0) SHALL complete in one cycle: store bytes committed at the accepting edge, load result on read_value with read_valid=1 for exactly the following cycle.
REQ-019 A crossing access (hword at offset 3; word at offset 1..3) SHALL be split: FSM IDLE -> SECOND on acceptance, SECOND -> IDLE after one cycle.
REQ-020 In SECOND, ready SHALL be 0; the request fields are latched at acceptance and the inputs are ignored.
REQ-021 Split store: low-address bytes SHALL be written at the accepting edge, remaining bytes into word (w+1) mod DEPTH_WORDS at the SECOND edge.
REQ-022 Split load: read_valid SHALL pulse the cycle after the SECOND edge, with both halves merged, giving two cycles of latency.
REQ-023 Extension SHALL apply to bit 7 (byte) or bit 15 (hword); word loads SHALL ignore sign_extend.
REQ-024 Unused upper write_value bits SHALL be ignored; bytes outside the access SHALL be unchanged.
REQ-025 A load issued on the edge after a store to the same bytes SHALL return the new data.
REQ-026 An undefined load_type encoding SHALL be treated as word.

Reset
REQ-027 On reset: FSM=IDLE, ready=1, read_valid=0, misaligned_fault=0, read_value=0; memory contents are not cleared.
REQ-028 Reset during SECOND SHALL abort the split: the first half already written stays; the second half is discarded; no read_valid is issued.

Configuration
REQ-029 Macro MISALIGNED_SPLIT_EN: when defined, crossing accesses SHALL use the split FSM (REQ-019..022).
REQ-030 Without MISALIGNED_SPLIT_EN: a crossing access SHALL write no bytes and assert misaligned_fault for one cycle after acceptance, with no read_valid; ready SHALL stay 1, and the SECOND state SHALL be absent.

Verification
REQ-031 Write word 0x00000000 to addrs 0..20 step 4, then byte writes 0xFE,0x04,0xF8,0x10 at addrs 0,3,6,9; zero-extended byte loads at addrs 0..6 -> 0x000000FE,0,0,0x04,0,0,0xF8; sign-extended -> 0xFFFFFFFE,0,0,0x00000004,0,0,0xFFFFFFF8.
REQ-032 hword store 0xF830 at addr 6; sign-extended hword load at addr 6 -> 0xFFFFF830; zero-extended -> 0x0000F830.
REQ-033 With macro: word store 0xAABBCCDD at addr 5 -> ready low for one cycle; word1 bytes[3:1]=DD,CC,BB; word2 byte0=AA; word load at addr 5 -> 0xAABBCCDD with read_valid two cycles after acceptance.
REQ-034 With macro: word store 0x11223344 at addr 4*DEPTH_WORDS-2 -> bytes 0x44,0x33 at the last word offsets 2,3; 0x22,0x11 at word 0 offsets 0,1.
REQ-035 Reset pulse during SECOND of a split store at addr 7 -> only the word1 byte3 changes; ready=1 and read_valid=0 after reset.
REQ-036 Without macro: word load at addr 2 -> misaligned_fault=1 for one cycle, read_valid=0, memory unchanged; read+write together at addr 0 -> write performed, no read_valid.
